// File: rtl/quad_decoder_pkg.sv
// quad_decoder_pkg: shared FSM states, Gray phase constants and step classification
//   state_t    INIT/RUN decoder state
//   step_t     classification of a stable-phase transition
//   classify   (old phase, new phase) -> NONE / UP / DN / ILL
package quad_decoder_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ILL} step_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    // Position of a phase in the forward cycle 00->01->11->10 (Gray to binary).
    function automatic logic [1:0] phase_idx(input logic [1:0] ph);
        return {ph[1], ph[1] ^ ph[0]};
    endfunction

    // A forward step advances the cycle index by one, a reverse step by minus one;
    // a distance of two means both pins flipped at once, which is illegal.
    function automatic step_t classify(input logic [1:0] old_ph, input logic [1:0] new_ph);
        logic [1:0] d;
        d = phase_idx(new_ph) - phase_idx(old_ph);
        return d == 2'd0 ? STEP_NONE : d == 2'd1 ? STEP_UP : d == 2'd3 ? STEP_DN : STEP_ILL;
    endfunction

endpackage

// File: rtl/quad_decoder_input_filter.sv
// quad_input_filter: 2-FF synchroniser plus debounce for a 2-bit pin bus
//   clk, rst       clock, synchronous active-high reset
//   pins[1:0]      asynchronous pin pair {a,b}
//   arm            count even when the candidate equals stable (forces the first load)
//   stable[1:0]    debounced pin pair
//   stable_valid   one-cycle strobe when stable is loaded
module quad_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pins,
    input  logic       arm,
    output logic [1:0] stable,
    output logic       stable_valid
);

    localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    cand;
    logic [CW-1:0] cnt;

    // Any change of the synchronised value restarts the hold count, so only a
    // value held for FILTER_LEN consecutive cycles reaches stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= '0;
            s2           <= '0;
            cand         <= '0;
            cnt          <= '0;
            stable       <= '0;
            stable_valid <= 1'b0;
        end else begin
            s1           <= pins;
            s2           <= s1;
            stable_valid <= 1'b0;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cand != stable || arm) begin
                if (cnt == LAST) begin
                    stable       <= cand;
                    cnt          <= '0;
                    stable_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder decoder with debounce, step pulses and wrapping position
//   clk, rst          clock, synchronous active-high reset
//   enc_a, enc_b      asynchronous encoder channels
//   clear             synchronous clear of pos and err
//   pos               two's-complement wrapping position count
//   step_up, step_dn  one-cycle pulse per accepted forward / reverse step
//   dir               direction of last accepted step (1 = up)
//   err               sticky flag for an illegal two-bit transition
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int POS_BITS   = 16,
    parameter int FILTER_LEN = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enc_a,
    input  logic                enc_b,
    input  logic                clear,
    output logic [POS_BITS-1:0] pos,
    output logic                step_up,
    output logic                step_dn,
    output logic                dir,
    output logic                err
);

    state_t     state;
    state_t     state_nx;
    logic [1:0] stable;
    logic [1:0] prev;
    logic       stable_valid;
    logic       arm;
    logic       run;
    step_t      cls;

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk          (clk),
        .rst          (rst),
        .pins         ({enc_a, enc_b}),
        .arm          (arm),
        .stable       (stable),
        .stable_valid (stable_valid)
    );

    always_ff @(posedge clk) begin
        state <= rst ? ST_INIT : state_nx;
    end

    // The first load only captures the pin state present at reset release.
    always_comb begin
        state_nx = (state == ST_INIT && stable_valid) ? ST_RUN : state;
    end

    always_comb begin
        arm = state == ST_INIT;
        run = state == ST_RUN && stable_valid;
        cls = classify(prev, stable);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            pos     <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            dir     <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (stable_valid)
                prev <= stable;
            step_up <= run && cls == STEP_UP;
            step_dn <= run && cls == STEP_DN;
            if (run && (cls == STEP_UP || cls == STEP_DN))
                dir <= cls == STEP_UP;
            pos <= clear ? '0 :
                   (run && cls == STEP_UP) ? pos + 1'b1 :
                   (run && cls == STEP_DN) ? pos - 1'b1 : pos;
            err <= clear ? 1'b0 : err | (run && cls == STEP_ILL);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: self-checking scoreboard bench for quad_decoder
module tb_quad_decoder;

    typedef struct packed {
        logic        up;
        logic [15:0] pos;
        logic        dir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enc_a;
    logic        enc_b;
    logic        clear;
    logic [15:0] pos;
    logic        step_up;
    logic        step_dn;
    logic        dir;
    logic        err;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [1:0]  cur;
    logic [15:0] exp_pos;
    logic        exp_dir;
    logic        exp_err;
    int          lat;

    quad_decoder #(.POS_BITS(16), .FILTER_LEN(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .clear   (clear),
        .pos     (pos),
        .step_up (step_up),
        .step_dn (step_dn),
        .dir     (dir),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [1:0] p);
        case (p)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Drive a settled pin change and record what the decoder must report for it.
    task automatic put(input logic [1:0] v, input logic clr);
        logic up;
        logic dn;
        @(negedge clk);
        {enc_a, enc_b} = v;
        up = v == fwd(cur);
        dn = cur == fwd(v);
        if (up) exp_pos = exp_pos + 16'd1;
        if (dn) exp_pos = exp_pos - 16'd1;
        if (up || dn) exp_dir = up;
        if (!up && !dn && v != cur) exp_err = 1'b1;
        if (clr) begin
            exp_pos = '0;
            exp_err = 1'b0;
        end
        if (up || dn) q.push_back('{up: up, pos: exp_pos, dir: exp_dir});
        cur = v;
    endtask

    task automatic go(input logic [1:0] v, input int n);
        put(v, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    // Pin change with clear landing on the same edge that registers its step.
    task automatic go_clr(input logic [1:0] v);
        put(v, 1'b1);
        repeat (11) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic raw(input logic [1:0] v, input int n);
        @(negedge clk);
        {enc_a, enc_b} = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_pos = '0;
        exp_err = 1'b0;
    endtask

    always @(negedge clk) begin
        if (step_up && step_dn)
            chk("both_pulses", 32'(1), 32'(0));
        if (step_up || step_dn) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_step", 32'(1), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_up", 32'(step_up), 32'(e.up));
                chk("sb_dn", 32'(step_dn), 32'(!e.up));
                chk("sb_pos", 32'(pos), 32'(e.pos));
                chk("sb_dir", 32'(dir), 32'(e.dir));
            end
        end
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        {enc_a, enc_b} = 2'b11;
        cur = 2'b11;
        exp_pos = '0;
        exp_dir = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {12'd0, pos, step_up, step_dn, dir, err}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("init_pos", 32'(pos), 32'(0));
        chk("init_err", 32'(err), 32'(0));

        go(2'b10, 20);
        go(2'b00, 20);
        chk("pos_two", 32'(pos), 32'(exp_pos));
        pulse_clear();
        @(negedge clk);
        chk("clear_pos", 32'(pos), 32'(0));

        put(2'b01, 1'b0);
        lat = 99;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (step_up) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(11));
        repeat (10) @(negedge clk);
        go(2'b11, 20);
        go(2'b10, 20);
        go(2'b00, 20);
        chk("fwd_pos", 32'(pos), 32'(4));
        chk("fwd_dir", 32'(dir), 32'(1));
        pulse_clear();

        go(2'b10, 20);
        chk("wrap_dn_pos", 32'(pos), 32'(16'hFFFF));
        chk("wrap_dn_dir", 32'(dir), 32'(0));
        go(2'b00, 20);
        chk("wrap_up_pos", 32'(pos), 32'(0));

        raw(2'b10, 5);
        raw(2'b00, 20);
        chk("glitch_pos", 32'(pos), 32'(0));
        raw(2'b10, 3);
        raw(2'b00, 3);
        raw(2'b10, 3);
        raw(2'b00, 3);
        raw(2'b10, 3);
        raw(2'b00, 3);
        go(2'b10, 20);
        chk("bounce_pos", 32'(pos), 32'(16'hFFFF));
        go(2'b00, 20);

        go(2'b11, 20);
        chk("ill_err", 32'(err), 32'(1));
        chk("ill_pos", 32'(pos), 32'(0));
        go(2'b10, 20);
        go(2'b00, 20);
        chk("err_sticky", 32'(err), 32'(1));
        chk("pos_after_ill", 32'(pos), 32'(2));
        pulse_clear();
        @(negedge clk);
        chk("clr_err", 32'(err), 32'(0));
        chk("clr_pos", 32'(pos), 32'(0));
        go_clr(2'b01);
        chk("clr_step_pos", 32'(pos), 32'(0));
        go_clr(2'b10);
        chk("clr_ill_err", 32'(err), 32'(0));

        for (int i = 0; i < 37; i++)
            go(fwd(cur), 14);
        chk("pos_37", 32'(pos), 32'(37));

        raw(fwd(cur), 5);
        rst = 1'b1;
        {enc_a, enc_b} = 2'b10;
        @(negedge clk);
        chk("midrst_outs", {12'd0, pos, step_up, step_dn, dir, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cur = 2'b10;
        exp_pos = '0;
        exp_dir = 1'b0;
        exp_err = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst", {12'd0, pos, step_up, step_dn, dir, err}, 32'd0);
        chk("sb_drained", 32'(q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
